uart_rx: RTL
============

// Module: uart_rx
//
// PURPOSE
//  Serial receiver feeding the Wishbone serial controller's rx_req/rx_data input.
//  Deserialises an 8N1 async line (LSB first, idle high) into bytes.
//  Emits a one-cycle rx_req_o pulse per good byte; flags bad stop bits on rx_err_o.
//  Sits between the board RX pin and the serial-to-Wishbone controller.
//
// PARAMETERS
//  TICKS_PER_BAUD  104  clk_i cycles per bit (12 MHz / 115200); legal >= 4, elaborate-time error otherwise
//
// PORTS
//  clk_i      in   1  single clock
//  rst_ni     in   1  asynchronous active-low reset
//  rx_i       in   1  raw serial line, asynchronous to clk_i, idle high
//  rx_req_o   out  1  one-cycle pulse: rx_data_o holds a new valid byte
//  rx_data_o  out  8  last good byte; held until next good byte
//  rx_err_o   out  1  one-cycle pulse: framing error (stop bit sampled low)
//
// BEHAVIOUR
//  - Reset (async assert, sync release): rx_req_o=0, rx_err_o=0, rx_data_o=8'h00,
//    state=StIdle, sync flops=1 (line idle), counters=0. Reset mid-frame discards the frame.
//  - rx_i passes a 2-flop synchroniser; all decisions use the synchronised bit (rx_s).
//  - Counter cnt of width $clog2(TICKS_PER_BAUD); "tick" = cnt==0, else cnt decrements.
//  - States:
//    StIdle:  rx_s==0 -> StStart, cnt=TICKS_PER_BAUD/2-1.
//    StStart: on tick: rx_s==0 -> StData, cnt=TICKS_PER_BAUD-1, bit_idx=0;
//             rx_s==1 -> StIdle (glitch rejected, no pulse).
//    StData:  on tick: shift rx_s into MSB of shift reg (LSB-first line order),
//             cnt=TICKS_PER_BAUD-1; bit_idx==7 -> StStop, else bit_idx+1.
//    StStop:  on tick: rx_s==1 -> rx_data_o<=shift, rx_req_o<=1, -> StIdle;
//             rx_s==0 -> rx_err_o<=1, rx_data_o unchanged, -> StBreak.
//    StBreak: wait for rx_s==1 -> StIdle. No further pulses while line stays low.
//  - Pulses registered: rx_req_o/rx_err_o high exactly the cycle after the mid-stop sample,
//    never both; never high two consecutive cycles.
//  - Latency: line start edge to rx_req_o = 2 (sync) + 9.5 bit times + 1 cycle (+/-1 cycle).
//  - Back-to-back frames: StIdle re-entered at mid-stop, so a start bit immediately
//    after the stop bit is accepted with no lost byte.
//  - Downstream has no backpressure; consumer must take the byte on the rx_req_o cycle.
//
// STRUCTURE
//  - uart_pkg (shared with future uart_tx): UartDataBits=8, default TICKS_PER_BAUD constant.
//  - uart_rx_state_e {StIdle, StStart, StData, StStop, StBreak} local to this module.
//  - Sub-module: sync_2ff (2-flop synchroniser, async reset value parameter = 1).
//  - One always_ff (state/cnt/bit_idx/shift/outputs), one always_comb next-state.
//
// TESTING  (bench uses TICKS_PER_BAUD=8, idle line high)
//  - Send 0x55 -> exactly one rx_req_o pulse, rx_data_o=0x55, rx_err_o never high.
//  - Send 0x80 then 0xA5 back-to-back (no idle gap) -> two pulses, data 0x80 then 0xA5.
//  - Line low 2 cycles then high -> no rx_req_o/rx_err_o; next 0x3C received as 0x3C.
//  - 0x3C with stop bit forced low, then line high 1 bit, then 0x0F -> one rx_err_o pulse,
//    rx_data_o stays at previous value, then rx_req_o with 0x0F.
//  - Line held low 20 bit times -> exactly one rx_err_o pulse, no rx_req_o; after line
//    high, 0xC3 received correctly.
//  - rst_ni asserted during data bit 3 of 0xFF -> outputs 0 immediately (async); after
//    release and idle, 0x5A received; rx_data_o never shows a partial byte.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants for the receive and transmit paths
package uart_pkg;

    localparam int UartDataBits    = 8;
    localparam int UartTicksPerBaud = 104;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for an asynchronous single-bit input
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver: mid-bit sampling, one-cycle byte and framing-error pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICKS_PER_BAUD = UartTicksPerBaud
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    rx_i,
    output logic                    rx_req_o,
    output logic [UartDataBits-1:0] rx_data_o,
    output logic                    rx_err_o
);

    localparam int CntW = $clog2(TICKS_PER_BAUD);
    localparam int IdxW = $clog2(UartDataBits);
    localparam logic [CntW-1:0] CntFull = CntW'(TICKS_PER_BAUD - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(TICKS_PER_BAUD / 2 - 1);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(UartDataBits - 1);

    generate
        if (TICKS_PER_BAUD < 4) begin : g_bad_param
            $error("uart_rx: TICKS_PER_BAUD must be >= 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } uart_rx_state_e;

    logic w_rx_s;
    logic w_tick;

    uart_rx_state_e          r_state, w_state_nxt;
    logic [CntW-1:0]         r_cnt, w_cnt_nxt;
    logic [IdxW-1:0]         r_bit_idx, w_bit_idx_nxt;
    logic [UartDataBits-1:0] r_shift, w_shift_nxt;
    logic [UartDataBits-1:0] r_data, w_data_nxt;
    logic                    r_req, w_req_nxt;
    logic                    r_err, w_err_nxt;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (w_rx_s)
    );

    assign w_tick = (r_cnt == '0);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_idx_nxt = r_bit_idx;
        w_shift_nxt   = r_shift;
        w_data_nxt    = r_data;
        w_req_nxt     = 1'b0;
        w_err_nxt     = 1'b0;

        // Counting states share the same reload-or-decrement; only tick actions differ.
        if (r_state != StIdle && r_state != StBreak && !w_tick) begin
            w_cnt_nxt = r_cnt - 1'b1;
        end

        unique case (r_state)
            StIdle: begin
                if (!w_rx_s) begin
                    w_state_nxt = StStart;
                    w_cnt_nxt   = CntHalf;
                end
            end
            StStart: begin
                if (w_tick) begin
                    if (!w_rx_s) begin
                        w_state_nxt   = StData;
                        w_cnt_nxt     = CntFull;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    w_shift_nxt = {w_rx_s, r_shift[UartDataBits-1:1]};
                    w_cnt_nxt   = CntFull;
                    if (r_bit_idx == IdxLast) begin
                        w_state_nxt = StStop;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            StStop: begin
                if (w_tick) begin
                    if (w_rx_s) begin
                        w_data_nxt  = r_shift;
                        w_req_nxt   = 1'b1;
                        w_state_nxt = StIdle;
                    end else begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = StBreak;
                    end
                end
            end
            StBreak: begin
                if (w_rx_s) begin
                    w_state_nxt = StIdle;
                end
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_req     <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit_idx <= w_bit_idx_nxt;
            r_shift   <= w_shift_nxt;
            r_data    <= w_data_nxt;
            r_req     <= w_req_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign rx_req_o  = r_req;
    assign rx_err_o  = r_err;
    assign rx_data_o = r_data;

endmodule
